// File: rtl/tile_scheduler.sv
// Tile scheduler: latches one triangle, computes its screen-clamped tile bounding box and
// issues one (triangle, tile) job per covered tile in row-major order over valid/ready.
//
// state | meaning
// IDLE  | waiting for a triangle, tri_rdy high
// BBOX  | one cycle: bounding box, cull decision, tile counters loaded
// ISSUE | presenting tile jobs to raster until the last one is accepted
module tile_scheduler #(
    parameter int TILE_SHIFT   = 5,
    parameter int TILE_COLUMNS = 20,
    parameter int TILE_ROWS    = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tri_vld,
    output logic        tri_rdy,
    input  logic [27:0] v0_in,
    input  logic [27:0] v1_in,
    input  logic [27:0] v2_in,
    input  logic [3:0]  color_in,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [27:0] v0_out,
    output logic [27:0] v1_out,
    output logic [27:0] v2_out,
    output logic [15:0] meta_out,
    output logic        busy,
    output logic        tri_done,
    output logic        tri_cull
);

    localparam logic [9:0] X_LIM = 10'(TILE_COLUMNS << TILE_SHIFT);
    localparam logic [9:0] Y_LIM = 10'(TILE_ROWS << TILE_SHIFT);
    localparam logic [9:0] X_MAX = X_LIM - 10'd1;
    localparam logic [9:0] Y_MAX = Y_LIM - 10'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BBOX  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [27:0] v0_q, v1_q, v2_q;
    logic [3:0]  color_q;
    logic [4:0]  tx_min, tx_max, cur_tx;
    logic [3:0]  ty_max, cur_ty;
    logic        done_q;

    logic [9:0]  xmin, xmax, ymin, ymax, xmax_c, ymax_c;
    logic [4:0]  tx_lo, tx_hi;
    logic [3:0]  ty_lo, ty_hi;
    logic        cull, last_tile;

    function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b,
                                        input logic [9:0] c);
        logic [9:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b,
                                        input logic [9:0] c);
        logic [9:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Bounding box over the latched vertices; only meaningful during BBOX.
    always_comb begin
        xmin   = min3(v0_q[27:18], v1_q[27:18], v2_q[27:18]);
        xmax   = max3(v0_q[27:18], v1_q[27:18], v2_q[27:18]);
        ymin   = min3(v0_q[17:8], v1_q[17:8], v2_q[17:8]);
        ymax   = max3(v0_q[17:8], v1_q[17:8], v2_q[17:8]);
        cull   = (xmin >= X_LIM) || (ymin >= Y_LIM);
        xmax_c = (xmax > X_MAX) ? X_MAX : xmax;
        ymax_c = (ymax > Y_MAX) ? Y_MAX : ymax;
        tx_lo  = 5'(xmin >> TILE_SHIFT);
        tx_hi  = 5'(xmax_c >> TILE_SHIFT);
        ty_lo  = 4'(ymin >> TILE_SHIFT);
        ty_hi  = 4'(ymax_c >> TILE_SHIFT);
    end

    assign last_tile = (cur_tx == tx_max) && (cur_ty == ty_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        tri_rdy  = 1'b0;
        out_vld  = 1'b0;
        tri_cull = 1'b0;
        busy     = (state != IDLE);
        case (state)
            IDLE: begin
                tri_rdy = 1'b1;
                if (tri_vld) state_n = BBOX;
            end
            BBOX: begin
                tri_cull = cull;
                state_n  = cull ? IDLE : ISSUE;
            end
            ISSUE: begin
                out_vld = 1'b1;
                if (out_rdy && last_tile) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q    <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
            color_q <= '0;
            tx_min  <= '0;
            tx_max  <= '0;
            ty_max  <= '0;
            cur_tx  <= '0;
            cur_ty  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state == ISSUE) && out_rdy && last_tile;
            case (state)
                IDLE: begin
                    if (tri_vld) begin
                        v0_q    <= v0_in;
                        v1_q    <= v1_in;
                        v2_q    <= v2_in;
                        color_q <= color_in;
                    end
                end
                BBOX: begin
                    if (!cull) begin
                        tx_min <= tx_lo;
                        tx_max <= tx_hi;
                        ty_max <= ty_hi;
                        cur_tx <= tx_lo;
                        cur_ty <= ty_lo;
                    end
                end
                ISSUE: begin
                    if (out_rdy) begin
                        if (cur_tx != tx_max) begin
                            cur_tx <= cur_tx + 5'd1;
                        end else if (cur_ty != ty_max) begin
                            cur_tx <= tx_min;
                            cur_ty <= cur_ty + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign v0_out   = v0_q;
    assign v1_out   = v1_q;
    assign v2_out   = v2_q;
    assign meta_out = {color_q, 3'b000, cur_ty, cur_tx};
    assign tri_done = done_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Testbench for tile_scheduler: directed cases plus random triangles, checked by a
// scoreboard fed from a behavioural tile-coverage model.
module tb_tile_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tri_vld;
    logic        tri_rdy;
    logic [27:0] v0_in, v1_in, v2_in;
    logic [3:0]  color_in;
    logic        out_vld;
    logic        out_rdy;
    logic [27:0] v0_out, v1_out, v2_out;
    logic [15:0] meta_out;
    logic        busy, tri_done, tri_cull;

    tile_scheduler dut (
        .clk(clk), .rst_n(rst_n), .tri_vld(tri_vld), .tri_rdy(tri_rdy),
        .v0_in(v0_in), .v1_in(v1_in), .v2_in(v2_in), .color_in(color_in),
        .out_vld(out_vld), .out_rdy(out_rdy), .v0_out(v0_out), .v1_out(v1_out),
        .v2_out(v2_out), .meta_out(meta_out), .busy(busy), .tri_done(tri_done),
        .tri_cull(tri_cull)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [27:0] v0, v1, v2;
        logic [15:0] meta;
        logic        last;
    } job_t;

    job_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   rdy_hold = 1'b1;
    bit   done_pend = 1'b0;
    bit   stall_prev = 1'b0;
    logic [27:0] prev_v0, prev_v1, prev_v2;
    logic [15:0] prev_meta;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: tiles covered by the clamped bounding box, row-major.
    task automatic model(input logic [27:0] a, input logic [27:0] b, input logic [27:0] c,
                         input logic [3:0] col, output bit cull);
        int xs[3], ys[3];
        int xmn, xmx, ymn, ymx, txa, txb, tya, tyb;
        job_t j;
        xs[0] = int'(a[27:18]); xs[1] = int'(b[27:18]); xs[2] = int'(c[27:18]);
        ys[0] = int'(a[17:8]);  ys[1] = int'(b[17:8]);  ys[2] = int'(c[17:8]);
        xmn = xs[0]; xmx = xs[0]; ymn = ys[0]; ymx = ys[0];
        for (int i = 1; i < 3; i++) begin
            if (xs[i] < xmn) xmn = xs[i];
            if (xs[i] > xmx) xmx = xs[i];
            if (ys[i] < ymn) ymn = ys[i];
            if (ys[i] > ymx) ymx = ys[i];
        end
        cull = (xmn >= 640) || (ymn >= 480);
        if (!cull) begin
            if (xmx > 639) xmx = 639;
            if (ymx > 479) ymx = 479;
            txa = xmn / 32; txb = xmx / 32; tya = ymn / 32; tyb = ymx / 32;
            for (int ty = tya; ty <= tyb; ty++)
                for (int tx = txa; tx <= txb; tx++) begin
                    j.v0 = a; j.v1 = b; j.v2 = c;
                    j.meta = {col, 3'b000, 4'(ty), 5'(tx)};
                    j.last = (tx == txb) && (ty == tyb);
                    sb.push_back(j);
                end
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!tri_rdy && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        if (!tri_rdy) chk("idle_timeout", 32'(tri_rdy), 32'd1);
    endtask

    task automatic send_tri(input int x0, input int y0, input int x1, input int y1,
                            input int x2, input int y2, input logic [3:0] col);
        logic [27:0] a, b, c;
        bit cull;
        a = {10'(x0), 10'(y0), 8'($urandom)};
        b = {10'(x1), 10'(y1), 8'($urandom)};
        c = {10'(x2), 10'(y2), 8'($urandom)};
        wait_idle();
        model(a, b, c, col, cull);
        v0_in = a; v1_in = b; v2_in = c; color_in = col; tri_vld = 1'b1;
        @(posedge clk); #1;
        tri_vld = 1'b0;
        chk("bbox_cull", 32'(tri_cull), 32'(cull));
        chk("bbox_busy", 32'(busy), 32'd1);
        chk("bbox_vld", 32'(out_vld), 32'd0);
        chk("bbox_rdy", 32'(tri_rdy), 32'd0);
        @(posedge clk); #1;
        if (cull) begin
            chk("cull_rdy", 32'(tri_rdy), 32'd1);
            chk("cull_pulse_len", 32'(tri_cull), 32'd0);
            chk("cull_vld", 32'(out_vld), 32'd0);
        end else begin
            chk("first_vld", 32'(out_vld), 32'd1);
        end
    endtask

    always begin
        @(posedge clk); #1;
        if (!rdy_hold) out_rdy = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard on every handshake, checks hold-stability and tri_done.
    always @(negedge clk) begin
        job_t e;
        if (!rst_n) begin
            done_pend  = 1'b0;
            stall_prev = 1'b0;
        end else begin
            chk("tri_done", 32'(tri_done), 32'(done_pend));
            if (done_pend) begin
                chk("done_rdy", 32'(tri_rdy), 32'd1);
                chk("done_vld", 32'(out_vld), 32'd0);
            end
            done_pend = 1'b0;
            if (stall_prev) begin
                chk("hold_vld", 32'(out_vld), 32'd1);
                chk("hold_meta", 32'(meta_out), 32'(prev_meta));
                chk("hold_v0", 32'(v0_out), 32'(prev_v0));
                chk("hold_v1", 32'(v1_out), 32'(prev_v1));
                chk("hold_v2", 32'(v2_out), 32'(prev_v2));
            end
            if (out_vld) begin
                if (sb.size() == 0) begin
                    chk("unexpected_job", 32'(out_vld), 32'd0);
                end else if (out_rdy) begin
                    e = sb.pop_front();
                    chk("job_meta", 32'(meta_out), 32'(e.meta));
                    chk("job_v0", 32'(v0_out), 32'(e.v0));
                    chk("job_v1", 32'(v1_out), 32'(e.v1));
                    chk("job_v2", 32'(v2_out), 32'(e.v2));
                    done_pend = e.last;
                end
            end
            stall_prev = out_vld && !out_rdy;
            prev_meta = meta_out; prev_v0 = v0_out; prev_v1 = v1_out; prev_v2 = v2_out;
        end
    end

    task automatic count_hs(input int n);
        int hs = 0;
        int k = 0;
        while (hs < n && k < 200) begin
            @(negedge clk);
            if (out_vld && out_rdy) hs++;
            k++;
        end
        if (hs < n) chk("hs_timeout", 32'(hs), 32'(n));
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int mode, bx, by;
        rst_n = 1'b0; tri_vld = 1'b0; out_rdy = 1'b0;
        v0_in = '0; v1_in = '0; v2_in = '0; color_in = '0;
        #3;
        chk("rst_vld", 32'(out_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(tri_done), 32'd0);
        chk("rst_cull", 32'(tri_cull), 32'd0);
        chk("rst_meta", 32'(meta_out), 32'd0);
        chk("rst_v0", 32'(v0_out), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_rdy", 32'(tri_rdy), 32'd1);

        out_rdy = 1'b1;
        send_tri(10, 10, 20, 10, 10, 20, 4'd5);
        chk("single_meta", 32'(meta_out), 32'h5000);
        send_tri(30, 30, 70, 30, 30, 40, 4'd3);
        send_tri(700, 10, 750, 200, 800, 100, 4'd7);
        send_tri(600, 470, 1000, 470, 600, 1000, 4'd9);

        // Stall on job 3 for five cycles.
        send_tri(30, 30, 70, 30, 30, 40, 4'd3);
        count_hs(2);
        out_rdy = 1'b0;
        repeat (5) begin
            chk("stall_meta", 32'(meta_out), 32'h3002);
            @(posedge clk); #1;
        end
        out_rdy = 1'b1;
        wait_idle();

        // Reset while job 4 is presented.
        send_tri(30, 30, 70, 30, 30, 40, 4'd3);
        count_hs(3);
        chk("job4_meta", 32'(meta_out), 32'h3020);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(out_vld), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        chk("post_rst_rdy", 32'(tri_rdy), 32'd1);
        send_tri(100, 200, 130, 260, 90, 230, 4'd12);
        wait_idle();

        rdy_hold = 1'b0;
        for (int t = 0; t < 40; t++) begin
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                send_tri($urandom_range(0, 1023), $urandom_range(0, 1023),
                         $urandom_range(0, 1023), $urandom_range(0, 1023),
                         $urandom_range(0, 1023), $urandom_range(0, 1023), 4'($urandom));
            end else begin
                bx = $urandom_range(0, 700);
                by = $urandom_range(0, 520);
                send_tri(bx + $urandom_range(0, 80), by + $urandom_range(0, 80),
                         bx + $urandom_range(0, 80), by + $urandom_range(0, 80),
                         bx + $urandom_range(0, 80), by + $urandom_range(0, 80), 4'($urandom));
            end
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
